rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 10, word address width of the shared ROM and of both request ports.
REQ-002 Parameter DATA_BITS, default 32, ROM word width.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_valid  input  1  port 0 (instruction fetch) request present.
REQ-006 req0_addr  input  ADDR_BITS  port 0 word address.
REQ-007 req0_ready  output  1  port 0 request accepted this cycle.
REQ-008 rsp0_valid  output  1  port 0 read data valid.
REQ-009 rsp0_data  output  DATA_BITS  port 0 read data.
REQ-010 rsp0_ready  input  1  port 0 consumes response.
REQ-011 req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_ready: port 1 (data load) equivalents of REQ-005..REQ-010, same directions and widths.
REQ-012 rom_addr  output  ADDR_BITS  address to the combinational ROM.
REQ-013 rom_sel  output  1  ROM enable; ROM returns 0 when low.
REQ-014 rom_dout  input  DATA_BITS  combinational ROM data, valid same cycle as rom_addr/rom_sel.

Function
REQ-015 At most one request SHALL be granted per cycle; a grant is req_valid and req_ready both high on a port.
REQ-016 Port n SHALL be eligible only when reqn_valid=1 and its response slot is empty, or rspn_valid=1 and rspn_ready=1 in the same cycle (pass-through refill).
REQ-017 With one eligible port, that port SHALL be granted.
REQ-018 With both eligible, the winner SHALL follow the arbitration policy of REQ-030/REQ-031.
REQ-019 In a grant cycle rom_sel SHALL be 1 and rom_addr SHALL equal the winner's address; otherwise rom_sel=0 and rom_addr=0.
REQ-020 reqn_ready SHALL be combinational from valid, slot state and arbitration; it SHALL NOT depend on rom_dout.
REQ-021 On a grant, rom_dout SHALL be registered into the winner's response slot; rspn_valid=1 and rspn_data valid the next cycle (latency exactly 1 cycle).
REQ-022 rspn_valid and rspn_data SHALL hold stable until the cycle rspn_ready=1; the slot then empties unless refilled per REQ-016.
REQ-023 rspn_data SHALL be 0 whenever rspn_valid=0.
REQ-024 Responses per port SHALL return in request order; each port holds at most one outstanding response.
REQ-025 A stalled response on one port (rspn_ready=0) SHALL NOT block grants to the other port.
REQ-026 Requests with reqn_valid=0 SHALL NOT affect arbitration state.

Reset
REQ-027 While rst=1 at a rising edge: rsp0_valid=rsp1_valid=0, rsp0_data=rsp1_data=0, round-robin pointer=port 0 priority.
REQ-028 During a cycle with rst=1, req0_ready=req1_ready=0 and rom_sel=0; requests presented then are not granted and not recorded.
REQ-029 Reset asserted with a response pending SHALL discard it; no response for that request appears after reset.

Configuration
REQ-030 With macro ROM_ARB_RR_EN defined: round-robin; 1-bit pointer names the preferred port, flips to the other port after every contested grant, unchanged on uncontested grants.
REQ-031 Without ROM_ARB_RR_EN: fixed priority, port 0 always wins contested cycles; pointer logic absent.

Verification
REQ-032 Single port 0 read, addr=0x004, ROM word 0x3C011001, rsp0_ready=1 -> req0_ready=1 cycle T, rsp0_valid=1 and rsp0_data=0x3C011001 at T+1, rsp0_valid=0 at T+2.
REQ-033 Both ports request every cycle, addr0=0x010, addr1=0x020, both rsp_ready=1, RR_EN defined -> grants alternate 0,1,0,1 starting with port 0 after reset; without RR_EN -> port 1 never granted.
REQ-034 Port 1 rsp1_ready=0 for 5 cycles after one grant, port 0 streaming -> port 1 response held unchanged 5 cycles, req1_ready=0 meanwhile, port 0 granted every cycle.
REQ-035 Back-to-back port 0 reads addr 0x000,0x001,0x002 with rsp0_ready=1 -> one grant per cycle, responses in order on consecutive cycles.
REQ-036 rst=1 asserted the cycle after a port 0 grant -> rsp0_valid=0, rsp0_data=0 after reset, no stale response delivered, next grant goes to port 0 when contested.

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational ROM between an instruction-fetch port
// (port 0) and a data-load port (port 1). Each port owns a single-entry
// response slot; read data returns exactly one cycle after the grant.
// Configuration macro: ROM_ARB_RR_EN selects round-robin arbitration between
// contending ports; when undefined, port 0 has fixed priority.
module rom_arbiter #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    input  logic [ADDR_BITS-1:0] req0_addr,
    output logic                 req0_ready,
    output logic                 rsp0_valid,
    output logic [DATA_BITS-1:0] rsp0_data,
    input  logic                 rsp0_ready,

    input  logic                 req1_valid,
    input  logic [ADDR_BITS-1:0] req1_addr,
    output logic                 req1_ready,
    output logic                 rsp1_valid,
    output logic [DATA_BITS-1:0] rsp1_data,
    input  logic                 rsp1_ready,

    output logic [ADDR_BITS-1:0] rom_addr,
    output logic                 rom_sel,
    input  logic [DATA_BITS-1:0] rom_dout
);

    logic elig0;
    logic elig1;
    logic contested;
    logic grant0;
    logic grant1;
    logic prefer1;

`ifdef ROM_ARB_RR_EN
    logic rr_ptr;

    // Preferred-port pointer: hands priority to the other port after each contested grant
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (contested) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    assign prefer1 = rr_ptr;
`else
    assign prefer1 = 1'b0;
`endif

    // Eligibility and grant: a port may win only if its slot is free or draining this cycle
    always_comb begin
        elig0     = 1'b0;
        elig1     = 1'b0;
        contested = 1'b0;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (!rst) begin
            elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
            elig1 = req1_valid && (!rsp1_valid || rsp1_ready);
        end
        contested = elig0 && elig1;
        grant0    = elig0 && (!elig1 || !prefer1);
        grant1    = elig1 && (!elig0 || prefer1);
    end

    // ROM drive: the winner's address with the enable, otherwise an idle zero bus
    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        rom_sel    = grant0 || grant1;
        rom_addr   = '0;
        if (grant0) begin
            rom_addr = req0_addr;
        end else if (grant1) begin
            rom_addr = req1_addr;
        end
    end

    // Port 0 response slot: capture on grant, hold until consumed, clear data when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
        end else if (grant0) begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= rom_dout;
        end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
        end
    end

    // Port 1 response slot: same behaviour as port 0, independent stall
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
        end else if (grant1) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= rom_dout;
        end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed plus random stimulus for rom_arbiter against a
// behavioural ROM; expected read data is queued per port at grant time and
// popped when the bench consumes the response.
module tb_rom_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [9:0]  req0_addr;
    logic        req0_ready;
    logic        rsp0_valid;
    logic [31:0] rsp0_data;
    logic        rsp0_ready;
    logic        req1_valid;
    logic [9:0]  req1_addr;
    logic        req1_ready;
    logic        rsp1_valid;
    logic [31:0] rsp1_data;
    logic        rsp1_ready;
    logic [9:0]  rom_addr;
    logic        rom_sel;
    logic [31:0] rom_dout;

    int test_count = 0;
    int fail_count = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic        model_ptr = 1'b0;

    rom_arbiter #(.ADDR_BITS(10), .DATA_BITS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_ready (rsp0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_ready (rsp1_ready),
        .rom_addr   (rom_addr),
        .rom_sel    (rom_sel),
        .rom_dout   (rom_dout)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ROM contents: word 4 is fixed, others are address-derived
    function automatic logic [31:0] romWord(input logic [9:0] a);
        if (a == 10'h004) begin
            return 32'h3C01_1001;
        end
        return 32'hA500_0000 ^ {a, 12'h000, a};
    endfunction

    // Combinational ROM that reads zero when not selected
    assign rom_dout = rom_sel ? romWord(rom_addr) : 32'h0;

    // One comparison with failure reporting
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, check mid-cycle, advance the model
    task automatic applyStimulus(input logic r,
                                 input logic v0, input logic [9:0] a0, input logic rr0,
                                 input logic v1, input logic [9:0] a1, input logic rr1);
        logic        e0;
        logic        e1;
        logic        g0;
        logic        g1;
        logic [9:0]  exp_addr;
        @(posedge clk);
        #1;
        rst        = r;
        req0_valid = v0;
        req0_addr  = a0;
        rsp0_ready = rr0;
        req1_valid = v1;
        req1_addr  = a1;
        rsp1_ready = rr1;
        @(negedge clk);

        e0 = !r && v0 && (exp_q0.size() == 0 || rr0);
        e1 = !r && v1 && (exp_q1.size() == 0 || rr1);
`ifdef ROM_ARB_RR_EN
        g0 = e0 && (!e1 || !model_ptr);
        g1 = e1 && (!e0 || model_ptr);
`else
        g0 = e0;
        g1 = e1 && !e0;
`endif
        exp_addr = g0 ? a0 : (g1 ? a1 : 10'h000);

        checkOutput("req0_ready", {31'h0, req0_ready}, {31'h0, g0});
        checkOutput("req1_ready", {31'h0, req1_ready}, {31'h0, g1});
        checkOutput("rom_sel",    {31'h0, rom_sel},    {31'h0, g0 || g1});
        checkOutput("rom_addr",   {22'h0, rom_addr},   {22'h0, exp_addr});
        checkOutput("rsp0_valid", {31'h0, rsp0_valid}, {31'h0, exp_q0.size() != 0});
        checkOutput("rsp0_data",  rsp0_data, (exp_q0.size() != 0) ? exp_q0[0] : 32'h0);
        checkOutput("rsp1_valid", {31'h0, rsp1_valid}, {31'h0, exp_q1.size() != 0});
        checkOutput("rsp1_data",  rsp1_data, (exp_q1.size() != 0) ? exp_q1[0] : 32'h0);

        if (r) begin
            exp_q0.delete();
            exp_q1.delete();
            model_ptr = 1'b0;
        end else begin
            if (exp_q0.size() != 0 && rr0) void'(exp_q0.pop_front());
            if (exp_q1.size() != 0 && rr1) void'(exp_q1.pop_front());
            if (g0) exp_q0.push_back(romWord(a0));
            if (g1) exp_q1.push_back(romWord(a1));
            if (e0 && e1) model_ptr = ~model_ptr;
        end
    endtask

    // Directed sequence followed by a random tail
    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req0_addr  = 10'h0;
        rsp0_ready = 1'b1;
        req1_valid = 1'b0;
        req1_addr  = 10'h0;
        rsp1_ready = 1'b1;

        // Reset with requests present: nothing granted
        applyStimulus(1, 1, 10'h011, 1, 1, 10'h022, 1);
        applyStimulus(1, 1, 10'h011, 1, 1, 10'h022, 1);

        // Single port 0 read of word 4
        applyStimulus(0, 1, 10'h004, 1, 0, 10'h000, 1);
        applyStimulus(0, 0, 10'h000, 1, 0, 10'h000, 1);
        applyStimulus(0, 0, 10'h000, 1, 0, 10'h000, 1);

        // Both ports contending every cycle
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 10'h010, 1, 1, 10'h020, 1);
        end
        applyStimulus(0, 0, 10'h000, 1, 0, 10'h000, 1);
        applyStimulus(0, 0, 10'h000, 1, 0, 10'h000, 1);

        // Port 1 stalled for five cycles while port 0 streams
        applyStimulus(0, 0, 10'h000, 1, 1, 10'h030, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 10'(10'h040 + i), 1, 1, 10'h031, 0);
        end
        applyStimulus(0, 0, 10'h000, 1, 0, 10'h000, 1);
        applyStimulus(0, 0, 10'h000, 1, 0, 10'h000, 1);

        // Back-to-back port 0 reads
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 10'(i), 1, 0, 10'h000, 1);
        end
        applyStimulus(0, 0, 10'h000, 1, 0, 10'h000, 1);
        applyStimulus(0, 0, 10'h000, 1, 0, 10'h000, 1);

        // Reset right after a port 0 grant discards the pending response
        applyStimulus(0, 1, 10'h055, 0, 0, 10'h000, 0);
        applyStimulus(1, 0, 10'h000, 0, 0, 10'h000, 0);
        applyStimulus(0, 0, 10'h000, 1, 0, 10'h000, 1);
        applyStimulus(0, 1, 10'h066, 1, 1, 10'h077, 1);
        applyStimulus(0, 0, 10'h000, 1, 0, 10'h000, 1);
        applyStimulus(0, 0, 10'h000, 1, 0, 10'h000, 1);

        // Random traffic with random back-pressure
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0,
                          1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
